// File: rtl/adder_mult_pkg.sv
// adder_mult_pkg: shared definitions for the shift-add multiplier sequencer.
//   CMD_ADD / CMD_SUB : adder_subtracter command codes
//   state_t           : sequencer FSM state encoding
package adder_mult_pkg;

  localparam logic [2:0] CMD_ADD = 3'b000;
  localparam logic [2:0] CMD_SUB = 3'b001;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/adder_mult_fsm.sv
// adder_mult_fsm: control FSM for the shift-add multiplier.
// Holds the state register, the iteration counter and the registered
// busy/done outputs.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   start        : request pulse, honoured only in IDLE or DONE
//   bypass       : accepted start should skip RUN and go straight to DONE
//   accept       : start is being accepted this cycle (combinational)
//   last         : current RUN cycle is the final iteration (combinational)
//   busy         : registered, high exactly in RUN
//   done         : registered, high exactly in DONE
module adder_mult_fsm
  import adder_mult_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic bypass,
  output logic accept,
  output logic last,
  output logic busy,
  output logic done
);

  state_t           state;
  logic [CNT_W-1:0] count;

  assign accept = start && ((state == S_IDLE) || (state == S_DONE));
  assign last   = (state == S_RUN) && (count == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          count <= '0;
          if (start && bypass) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (start) begin
            state <= S_RUN;
            busy  <= 1'b1;
            done  <= 1'b0;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        end
        S_RUN: begin
          count <= count + 1'b1;
          if (count == CNT_W'(WIDTH - 1)) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          count <= '0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/adder_mult_sequencer.sv
// adder_mult_sequencer: multi-cycle unsigned shift-add multiplier that drives
// an external shared adder_subtracter for WIDTH iterations.
// Optional feature: define ADDER_MULT_ZERO_BYPASS_EN to finish immediately
// (product 0, no RUN cycles) when either operand is zero at start.
// Ports:
//   clk, reset_n        : clock, asynchronous active-low reset
//   start, op_a, op_b   : request and operands (captured on acceptance)
//   busy, done, product : status and 2*WIDTH-bit result
//   add_a, add_b, add_cmd : drive the shared adder
//   add_sum, add_carryout : adder results, consumed in the same cycle
module adder_mult_sequencer
  import adder_mult_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   add_a,
  output logic [WIDTH-1:0]   add_b,
  output logic [2:0]         add_cmd,
  input  logic [WIDTH-1:0]   add_sum,
  input  logic               add_carryout
);

  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] hi_next;
  logic [WIDTH-1:0] lo_next;
  logic             accept;
  logic             last;
  logic             bypass;

`ifdef ADDER_MULT_ZERO_BYPASS_EN
  assign bypass = (op_a == '0) || (op_b == '0);
`else
  assign bypass = 1'b0;
`endif

  adder_mult_fsm #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_fsm (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (start),
    .bypass (bypass),
    .accept (accept),
    .last   (last),
    .busy   (busy),
    .done   (done)
  );

  // The adder is only driven while the sequence owns it; outside RUN the
  // operands are held at zero.
  assign add_a   = busy ? hi : '0;
  assign add_b   = (busy && lo[0]) ? mcand : '0;
  assign add_cmd = CMD_ADD;

  // {carry, sum, lo} shifted right by one: carry enters the top of hi and
  // the sum's LSB moves into lo as the multiplier bit is consumed.
  assign hi_next = {add_carryout, add_sum[WIDTH-1:1]};
  assign lo_next = {add_sum[0], lo[WIDTH-1:1]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi      <= '0;
      lo      <= '0;
      mcand   <= '0;
      product <= '0;
    end else if (accept) begin
      mcand <= op_a;
      lo    <= op_b;
      hi    <= '0;
      if (bypass) begin
        product <= '0;
      end
    end else if (busy) begin
      hi <= hi_next;
      lo <= lo_next;
      if (last) begin
        product <= {hi_next, lo_next};
      end
    end
  end

endmodule
